sim_video_sink: RTL and testbench
=================================

SIM_VIDEO_SINK -- requirements
Module: sim_video_sink

Interface
REQ-001 SHALL have parameter H_PIX, default 16, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 10, lines per frame.
REQ-003 SHALL have parameter STALL_CYC, default 2, vtready-low cycles after each accepted beat; 0 means always ready.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  arm reception of one frame; sampled only in IDLE.
REQ-007 SHALL have port vtdata  input  8  pixel payload from the stream source.
REQ-008 SHALL have port vtvalid  input  1  source beat valid.
REQ-009 SHALL have port vtlast  input  1  source end-of-frame marker.
REQ-010 SHALL have port vtready  output  1  sink ready, registered.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-013 SHALL have port pix_cnt  output  16  accepted beats in current/last frame.
REQ-014 SHALL have port err_data  output  16  payload mismatch count, saturating at 16'hFFFF.
REQ-015 SHALL have port err_last  output  1  sticky vtlast placement error.

Function
REQ-016 SHALL implement FSM IDLE, RECV, STALL, DONE; vtready = 1 only in RECV.
REQ-017 IDLE: start=1 -> RECV next cycle; pix_cnt, err_data, err_last, expected position (ex, ey) cleared on that edge.
REQ-018 Handshake SHALL be vtvalid && vtready in the same cycle; no other condition accepts a beat.
REQ-019 Each handshake: pix_cnt +1; expected payload = {ey[3:0], ex[3:0]}; if vtdata differs, err_data +1 (saturating).
REQ-020 Expected position: ex wraps H_PIX-1 -> 0; on that wrap ey +1, wrapping V_LINES-1 -> 0.
REQ-021 Expected last = (ex==H_PIX-1 && ey==V_LINES-1); on handshake, vtlast != expected last SHALL set err_last.
REQ-022 Handshake with vtlast=1 SHALL go to DONE regardless of position (early last ends frame).
REQ-023 Handshake at expected last with vtlast=0: err_last set, positions wrap to (0,0), reception continues.
REQ-024 Handshake with vtlast=0: STALL_CYC>0 -> STALL for exactly STALL_CYC cycles, then RECV; STALL_CYC=0 -> stay RECV (one beat per cycle).
REQ-025 vtvalid low in RECV SHALL leave all counters and state unchanged.
REQ-026 DONE: frame_done=1 for exactly one cycle, then IDLE; frame_done asserted the cycle after the vtlast handshake.
REQ-027 pix_cnt, err_data, err_last SHALL hold after DONE until the next accepted start.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 Payload with vtvalid=0 SHALL never be compared.

Reset
REQ-030 rstn low SHALL asynchronously force state IDLE, vtready 0, busy 0, frame_done 0, pix_cnt 0, err_data 0, err_last 0, ex 0, ey 0, stall counter 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done pulse.
REQ-032 Reset release SHALL take effect on the first rising clk edge with rstn high.

Structure
REQ-033 Shared package sim_video_pkg SHALL hold H_PIX/V_LINES defaults, FSM state encoding, and the 8-bit pixel-pattern width, shared with the stream source.
REQ-034 Position tracking SHALL be one sub-module video_pos_cnt (ex/ey counters, wrap, expected-last flag), reusable by the source.

Verification
REQ-035 Source 16x10, 3-cycle inter-beat gap, STALL_CYC=2, start -> 160 beats, pix_cnt=160, err_data=0, err_last=0, one frame_done.
REQ-036 STALL_CYC=0, vtvalid held high -> vtready continuously high, 160 beats in 160 cycles, frame_done the cycle after beat 160.
REQ-037 Beat 37 payload forced to 8'hFF (expected 8'h25) -> err_data=1, err_last=0, pix_cnt=160.
REQ-038 vtlast on beat 100 -> err_last=1, pix_cnt=100, frame_done next cycle, IDLE after.
REQ-039 vtlast missing on beat 160, then 5 more beats with last on the 5th -> err_last=1, pix_cnt=165, err_data=0.
REQ-040 rstn low after beat 50 -> all outputs 0 within the reset cycle, no frame_done; start pulse in RECV ignored.

Source files
------------

// File: rtl/sim_video_pkg.sv
// Definitions shared by the simulated video stream source and sink:
// frame geometry defaults, FSM encoding and the pixel test pattern.
package sim_video_pkg;

   localparam int unsigned H_PIX_DEF   = 16;
   localparam int unsigned V_LINES_DEF = 10;
   localparam int unsigned PIX_W       = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRecv  = 2'd1,
      StStall = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Payload carried by the pixel at column ex, line ey.
   function automatic logic [PIX_W-1:0] pix_pattern(input logic [15:0] ex,
                                                    input logic [15:0] ey);
      return {ey[3:0], ex[3:0]};
   endfunction

endpackage

// File: rtl/video_pos_cnt.sv
// Raster position tracker: column/line counters with wrap and an
// end-of-frame flag. Used by both the stream source and the sink.
module video_pos_cnt
   import sim_video_pkg::*;
#(
   parameter int unsigned H_PIX   = H_PIX_DEF,
   parameter int unsigned V_LINES = V_LINES_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr,
   input  logic        adv,
   output logic [15:0] ex,
   output logic [15:0] ey,
   output logic        at_last
);

   logic [15:0] ex_q, ey_q;
   logic        x_wrap, y_wrap;

   assign x_wrap = (ex_q == 16'(H_PIX - 1));
   assign y_wrap = (ey_q == 16'(V_LINES - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_q <= '0;
         ey_q <= '0;
      end else if (clr) begin
         ex_q <= '0;
         ey_q <= '0;
      end else if (adv) begin
         if (x_wrap) begin
            ex_q <= '0;
            ey_q <= y_wrap ? 16'd0 : ey_q + 16'd1;
         end else begin
            ex_q <= ex_q + 16'd1;
         end
      end
   end

   assign ex      = ex_q;
   assign ey      = ey_q;
   assign at_last = x_wrap && y_wrap;

endmodule

// File: rtl/sim_video_sink.sv
// Simulation video sink: accepts one frame per start, checks payload and
// end-of-frame placement against the raster pattern, throttles with stalls.
module sim_video_sink
   import sim_video_pkg::*;
#(
   parameter int unsigned H_PIX     = H_PIX_DEF,
   parameter int unsigned V_LINES   = V_LINES_DEF,
   parameter int unsigned STALL_CYC = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [PIX_W-1:0] vtdata,
   input  logic             vtvalid,
   input  logic             vtlast,
   output logic             vtready,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      pix_cnt,
   output logic [15:0]      err_data,
   output logic             err_last
);

   state_e      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   logic        ready_q;
   logic [15:0] pix_cnt_q, err_data_q;
   logic        err_last_q;
   logic        arm, hs;
   logic [15:0] ex, ey;
   logic        at_last;

   assign arm = (state_q == StIdle) && start;
   assign hs  = vtvalid && ready_q;

   video_pos_cnt #(
      .H_PIX   (H_PIX),
      .V_LINES (V_LINES)
   ) u_pos (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (arm),
      .adv     (hs),
      .ex      (ex),
      .ey      (ey),
      .at_last (at_last)
   );

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRecv;
         StRecv: begin
            if (hs) begin
               if (vtlast) begin
                  state_d = StDone;
               end else if (STALL_CYC != 0) begin
                  state_d = StStall;
                  stall_d = 16'(STALL_CYC - 1);
               end
            end
         end
         StStall: begin
            if (stall_q == 16'd0) state_d = StRecv;
            else                  stall_d = stall_q - 16'd1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         stall_q    <= '0;
         ready_q    <= 1'b0;
         pix_cnt_q  <= '0;
         err_data_q <= '0;
         err_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         // Ready is registered from the next state so it is high exactly in RECV.
         ready_q <= (state_d == StRecv);
         if (arm) begin
            pix_cnt_q  <= '0;
            err_data_q <= '0;
            err_last_q <= 1'b0;
         end else if (hs) begin
            pix_cnt_q <= pix_cnt_q + 16'd1;
            if ((vtdata != pix_pattern(ex, ey)) && (err_data_q != 16'hFFFF)) begin
               err_data_q <= err_data_q + 16'd1;
            end
            if (vtlast != at_last) err_last_q <= 1'b1;
         end
      end
   end

   assign vtready    = ready_q;
   assign busy       = (state_q != StIdle);
   assign frame_done = (state_q == StDone);
   assign pix_cnt    = pix_cnt_q;
   assign err_data   = err_data_q;
   assign err_last   = err_last_q;

endmodule

// File: tb/tb_sim_video_sink.sv
// Bench for sim_video_sink: a stalling instance and a zero-stall instance driven
// by a stream source, checked against a frame-level arithmetic model.
module tb_sim_video_sink;

   localparam int H  = 16;
   localparam int V  = 10;
   localparam int HV = H * V;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0, vtvalid = 1'b0, vtlast = 1'b0;
   logic [7:0]  vtdata = 8'h00;
   logic        vtready, busy, frame_done, err_last;
   logic [15:0] pix_cnt, err_data;

   logic        z_start = 1'b0, z_vtvalid = 1'b0, z_vtlast = 1'b0;
   logic [7:0]  z_vtdata = 8'h00;
   logic        z_vtready, z_busy, z_frame_done, z_err_last;
   logic [15:0] z_pix_cnt, z_err_data;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   sim_video_sink #(.H_PIX(H), .V_LINES(V), .STALL_CYC(2)) dut (
      .clk(clk), .rstn(rstn), .start(start), .vtdata(vtdata), .vtvalid(vtvalid),
      .vtlast(vtlast), .vtready(vtready), .busy(busy), .frame_done(frame_done),
      .pix_cnt(pix_cnt), .err_data(err_data), .err_last(err_last)
   );

   sim_video_sink #(.H_PIX(H), .V_LINES(V), .STALL_CYC(0)) dut0 (
      .clk(clk), .rstn(rstn), .start(z_start), .vtdata(z_vtdata), .vtvalid(z_vtvalid),
      .vtlast(z_vtlast), .vtready(z_vtready), .busy(z_busy), .frame_done(z_frame_done),
      .pix_cnt(z_pix_cnt), .err_data(z_err_data), .err_last(z_err_last)
   );

   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   // Raster pattern of the i-th beat of a stream, frames repeating every HV beats.
   function automatic logic [7:0] pattern(input int i);
      int k;
      k = i % HV;
      return {4'((k / H) % V), 4'(k % H)};
   endfunction

   task automatic start_pulse();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge right after the handshake edge.
   task automatic send_beat(input logic [7:0] d, input logic l, input int gap);
      int n;
      vtvalid = 1'b0;
      vtlast  = 1'b0;
      repeat (gap) begin
         vtdata = 8'($urandom);
         @(negedge clk);
      end
      vtvalid = 1'b1;
      vtdata  = d;
      vtlast  = l;
      n = 0;
      while (vtready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL ready_timeout: vtready stayed %b, required 1", vtready);
      end
      @(negedge clk);
      vtvalid = 1'b0;
      vtlast  = 1'b0;
   endtask

   task automatic run_frame(input string name, input int nbeats, input int last_at,
                            input int bad_at, input bit rnd);
      logic [7:0] d;
      logic       l;
      int         exp_err = 0;
      bit         exp_el  = 1'b0;
      int         exp_done;
      start_pulse();
      exp_done = done_cnt + 1;
      for (int i = 0; i < nbeats; i++) begin
         d = pattern(i);
         l = (i == last_at);
         if (i == bad_at) d = 8'hFF;
         if (rnd && $urandom_range(0, 15) == 0) d = 8'($urandom);
         if (d != pattern(i)) exp_err++;
         if (l != ((i % HV) == HV - 1)) exp_el = 1'b1;
         send_beat(d, l, rnd ? int'($urandom_range(0, 4)) : 3);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL %s frame_done: got %b, required 1", name, frame_done);
      end
      checks++;
      if (pix_cnt !== 16'(nbeats)) begin
         errors++;
         $display("FAIL %s pix_cnt: got %0d, required %0d", name, pix_cnt, nbeats);
      end
      checks++;
      if (err_data !== 16'(exp_err)) begin
         errors++;
         $display("FAIL %s err_data: got %0d, required %0d", name, err_data, exp_err);
      end
      checks++;
      if (err_last !== exp_el) begin
         errors++;
         $display("FAIL %s err_last: got %b, required %b", name, err_last, exp_el);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done_cnt !== exp_done || pix_cnt !== 16'(nbeats)) begin
         errors++;
         $display("FAIL %s after_done: busy %b done_cnt %0d pix_cnt %0d, required 0 %0d %0d",
                  name, busy, done_cnt, pix_cnt, exp_done, nbeats);
      end
   endtask

   task automatic test_reset();
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({vtready, busy, frame_done, err_last, pix_cnt, err_data} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b %b %b %b %0d %0d, required all 0",
                  vtready, busy, frame_done, err_last, pix_cnt, err_data);
      end
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || vtready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy %b vtready %b, required 0 0", busy, vtready);
      end
   endtask

   task automatic test_no_stall();
      int gaps = 0;
      @(negedge clk) z_start = 1'b1;
      @(negedge clk) z_start = 1'b0;
      for (int i = 0; i < HV; i++) begin
         z_vtvalid = 1'b1;
         z_vtdata  = pattern(i);
         z_vtlast  = (i == HV - 1);
         if (z_vtready !== 1'b1) gaps++;
         @(negedge clk);
      end
      z_vtvalid = 1'b0;
      z_vtlast  = 1'b0;
      checks++;
      if (gaps !== 0) begin
         errors++;
         $display("FAIL nostall_ready: low cycles %0d, required 0", gaps);
      end
      checks++;
      if (z_frame_done !== 1'b1 || z_pix_cnt !== 16'(HV)) begin
         errors++;
         $display("FAIL nostall_done: frame_done %b pix_cnt %0d, required 1 %0d",
                  z_frame_done, z_pix_cnt, HV);
      end
      checks++;
      if (z_err_data !== 16'd0 || z_err_last !== 1'b0) begin
         errors++;
         $display("FAIL nostall_errs: err_data %0d err_last %b, required 0 0",
                  z_err_data, z_err_last);
      end
      @(negedge clk);
      checks++;
      if (z_busy !== 1'b0 || z_frame_done !== 1'b0) begin
         errors++;
         $display("FAIL nostall_idle: busy %b frame_done %b, required 0 0",
                  z_busy, z_frame_done);
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] rdy;
      int         d0;
      start_pulse();
      for (int i = 0; i < 50; i++) send_beat(pattern(i), 1'b0, int'($urandom_range(0, 2)));
      rdy[0] = vtready;
      @(negedge clk) rdy[1] = vtready;
      @(negedge clk) rdy[2] = vtready;
      checks++;
      if (rdy !== 3'b100) begin
         errors++;
         $display("FAIL stall_window: ready seq %b, required 100", rdy);
      end
      start = 1'b1;
      vtdata = 8'($urandom);
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || pix_cnt !== 16'd50) begin
         errors++;
         $display("FAIL start_ignored: busy %b pix_cnt %0d, required 1 50", busy, pix_cnt);
      end
      d0 = done_cnt;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({vtready, busy, frame_done, err_last, pix_cnt, err_data} !== 36'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got %b %b %b %b %0d %0d, required all 0",
                  vtready, busy, frame_done, err_last, pix_cnt, err_data);
      end
      @(negedge clk) rstn = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (done_cnt !== d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_nodone: done_cnt %0d busy %b, required %0d 0",
                  done_cnt, busy, d0);
      end
   endtask

   task automatic test_random();
      int last_at;
      for (int f = 0; f < 4; f++) begin
         last_at = ($urandom_range(0, 1) == 0) ? HV - 1 : int'($urandom_range(1, HV + 10));
         run_frame("random", last_at + 1, last_at, -1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      run_frame("nominal", HV, HV - 1, -1, 1'b0);
      test_no_stall();
      run_frame("bad_pixel", HV, HV - 1, 37, 1'b0);
      run_frame("early_last", 100, 99, -1, 1'b0);
      run_frame("late_last", HV + 5, HV + 4, -1, 1'b0);
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
